// File: rtl/fpu_uint64_to_fp80_pkg.sv
// Shared FPU definitions: FP80 field layout, exponent constants, converter state
// encoding and the normalization step reused by the BCD sequencers.
package fpu_uint64_to_fp80_pkg;

    localparam int FP80_SIGN_BIT = 79;
    localparam int FP80_EXP_MSB  = 78;
    localparam int FP80_EXP_LSB  = 64;
    localparam int FP80_MANT_MSB = 63;

    localparam logic [14:0] EXP_BIAS       = 15'd16383;
    localparam logic [14:0] EXP_UINT64_TOP = EXP_BIAS + 15'd63;
    localparam logic [14:0] EXP_SPECIAL    = 15'h7FFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_NORM = 1'b1
    } conv_state_t;

    typedef struct packed {
        logic [63:0] mant;
        logic [5:0]  cnt;
        logic        last;
    } norm_step_t;

    // One normalization action: finished, coarse 16-bit shift, or 1-bit shift.
    function automatic norm_step_t fpu_norm_step(input logic [63:0] mant, input logic [5:0] cnt);
        norm_step_t r;
        r.mant = mant;
        r.cnt  = cnt;
        r.last = 1'b0;
        if (mant[63]) begin
            r.last = 1'b1;
        end else if (mant[63:48] == 16'd0) begin
            r.mant = mant << 16;
            r.cnt  = cnt + 6'd16;
        end else begin
            r.mant = mant << 1;
            r.cnt  = cnt + 6'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fpu_uint64_to_fp80.sv
// Exact uint64 + sign to FP80 converter; iterative normalization under an
// IDLE/NORM FSM with an enable/done handshake.
module fpu_uint64_to_fp80
    import fpu_uint64_to_fp80_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] uint_in,
    input  logic        sign_in,
    output logic [79:0] fp_out,
    output logic        done,
    output logic        busy,
    output logic        flag_inexact
);

    conv_state_t state, state_nxt;
    logic [63:0] mant, mant_nxt;
    logic [5:0]  shift_cnt, cnt_nxt;
    logic        sign, sign_nxt;
    logic [79:0] fp_nxt;
    logic        done_nxt;
    norm_step_t  step;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mant      <= 64'd0;
            shift_cnt <= 6'd0;
            sign      <= 1'b0;
            fp_out    <= 80'd0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mant      <= mant_nxt;
            shift_cnt <= cnt_nxt;
            sign      <= sign_nxt;
            fp_out    <= fp_nxt;
            done      <= done_nxt;
        end
    end

    always_comb step = fpu_norm_step(mant, shift_cnt);

    always_comb begin
        state_nxt = state;
        mant_nxt  = mant;
        cnt_nxt   = shift_cnt;
        sign_nxt  = sign;
        fp_nxt    = fp_out;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    if (uint_in == 64'd0) begin
                        // Signed zero keeps its sign with a zero exponent.
                        fp_nxt   = {sign_in, 79'd0};
                        done_nxt = 1'b1;
                    end else begin
                        mant_nxt  = uint_in;
                        sign_nxt  = sign_in;
                        cnt_nxt   = 6'd0;
                        state_nxt = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (step.last) begin
                    fp_nxt[FP80_SIGN_BIT]               = sign;
                    fp_nxt[FP80_EXP_MSB:FP80_EXP_LSB]   = EXP_UINT64_TOP - {9'd0, shift_cnt};
                    fp_nxt[FP80_MANT_MSB:0]             = mant;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    mant_nxt = step.mant;
                    cnt_nxt  = step.cnt;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy         = (state != ST_IDLE);
    assign flag_inexact = 1'b0;

endmodule

// File: tb/tb_fpu_uint64_to_fp80.sv
// Scoreboard bench for fpu_uint64_to_fp80: directed vectors push expected
// results and done cycles; a negedge monitor pops and compares on done.
module tb_fpu_uint64_to_fp80;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] uint_in = 64'd0;
    logic        sign_in = 1'b0;
    logic [79:0] fp_out;
    logic        done;
    logic        busy;
    logic        flag_inexact;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [79:0] fp;
        int          due;
    } exp_t;
    exp_t sb[$];

    fpu_uint64_to_fp80 dut (
        .clk(clk), .reset(reset), .enable(enable), .uint_in(uint_in), .sign_in(sign_in),
        .fp_out(fp_out), .done(done), .busy(busy), .flag_inexact(flag_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h required=no_done (cycle %0d)", fp_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("fp_out", fp_out, e.fp);
                check("done_cycle", 80'(cyc), 80'(e.due));
                check("busy_in_done", {79'd0, busy}, 80'd0);
                check("flag_inexact", {79'd0, flag_inexact}, 80'd0);
            end
        end
    end

    // Hold enable for exactly one cycle; the done cycle is enable cycle + lat.
    task automatic start(input logic [63:0] u, input logic s, input logic [79:0] fp,
                         input int lat, input bit push);
        exp_t e;
        enable  = 1'b1;
        uint_in = u;
        sign_in = s;
        if (push) begin
            e.fp  = fp;
            e.due = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        enable  = 1'b0;
        uint_in = 64'd0;
        sign_in = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fp_out", fp_out, 80'd0);
        check("rst_done", {79'd0, done}, 80'd0);
        check("rst_busy", {79'd0, busy}, 80'd0);
        check("rst_flag", {79'd0, flag_inexact}, 80'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        start(64'd0, 1'b1, 80'h8000_0000_0000_0000_0000, 1, 1'b1);  drain();
        start(64'd0, 1'b0, 80'h0000_0000_0000_0000_0000, 1, 1'b1);  drain();
        start(64'd1, 1'b0, 80'h3FFF_8000_0000_0000_0000, 20, 1'b1); drain();
        start(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'hC03E_FFFF_FFFF_FFFF_FFFF, 2, 1'b1); drain();
        start(64'h1_0000, 1'b0, 80'h400F_8000_0000_0000_0000, 19, 1'b1); drain();
        start(64'd1234, 1'b0, 80'h4009_9A40_0000_0000_0000, 10, 1'b1); drain();

        // Enable while busy is ignored; enable in the done cycle is accepted.
        n0 = cyc;
        start(64'd1, 1'b0, 80'h3FFF_8000_0000_0000_0000, 20, 1'b1);
        wait_until(n0 + 5);
        start(64'd5, 1'b0, 80'd0, 0, 1'b0);
        wait_until(n0 + 20);
        start(64'd5, 1'b0, 80'h4001_A000_0000_0000_0000, 18, 1'b1);
        drain();

        // Reset mid-conversion aborts without a done pulse.
        n0 = cyc;
        start(64'd1, 1'b0, 80'd0, 0, 1'b0);
        wait_until(n0 + 4);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_done", {79'd0, done}, 80'd0);
        check("abort_fp_out", fp_out, 80'd0);
        check("abort_busy", {79'd0, busy}, 80'd0);
        repeat (25) @(posedge clk);
        #1;
        start(64'd1234, 1'b1, 80'hC009_9A40_0000_0000_0000, 10, 1'b1); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
